// File: rtl/ign_config_scheduler_pkg.sv
// rtl/ign_config_scheduler_pkg.sv - shared widths, field codes and FSM states for the config scheduler
package efi_cfg_pkg;

   localparam int PHASE_W = 8;
   localparam int TIME_W  = 24;

   typedef enum logic [1:0] {
      FLD_PHASE = 2'd0,
      FLD_DELAY = 2'd1,
      FLD_DWELL = 2'd2,
      FLD_EN    = 2'd3
   } fld_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_e;

   function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v,
                                                    input logic [TIME_W-1:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/ign_config_scheduler_if.sv
// rtl/ign_config_scheduler_if.sv - host write/commit and engine-sync signals of the config scheduler
interface ign_config_scheduler_if;

   logic                             synced;
   logic [efi_cfg_pkg::PHASE_W-1:0]  eng_phase;
   logic                             trigger;
   logic                             wr_en;
   logic [4:0]                       wr_addr;
   logic [efi_cfg_pkg::TIME_W-1:0]   wr_data;
   logic                             wr_ready;
   logic                             commit_req;
   logic                             commit_pending;
   logic                             commit_done;

   modport master (
      output synced, eng_phase, trigger, wr_en, wr_addr, wr_data, commit_req,
      input  wr_ready, commit_pending, commit_done
   );

   modport slave (
      input  synced, eng_phase, trigger, wr_en, wr_addr, wr_data, commit_req,
      output wr_ready, commit_pending, commit_done
   );

endinterface

// File: rtl/ign_config_scheduler_bank.sv
// rtl/ign_config_scheduler_bank.sv - one channel's shadow and active timing registers
module ign_cfg_bank
   import efi_cfg_pkg::*;
#(
   parameter logic [TIME_W-1:0] MAX_DWELL = 24'd20000
)
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en_i,
   input  fld_e               wr_field_i,
   input  logic [TIME_W-1:0]  wr_data_i,
   input  logic               commit_i,
   output logic [PHASE_W-1:0] phase_o,
   output logic [TIME_W-1:0]  delay_o,
   output logic [TIME_W-1:0]  dwell_o,
   output logic               en_o
);

   logic [PHASE_W-1:0] sh_phase_q, sh_phase_d, act_phase_q;
   logic [TIME_W-1:0]  sh_delay_q, sh_delay_d, act_delay_q;
   logic [TIME_W-1:0]  sh_dwell_q, sh_dwell_d, act_dwell_q;
   logic               sh_en_q,    sh_en_d,    act_en_q;

   always_comb begin
      sh_phase_d = sh_phase_q;
      sh_delay_d = sh_delay_q;
      sh_dwell_d = sh_dwell_q;
      sh_en_d    = sh_en_q;
      if (wr_en_i) begin
         case (wr_field_i)
            FLD_PHASE: sh_phase_d = wr_data_i[PHASE_W-1:0];
            FLD_DELAY: sh_delay_d = wr_data_i;
            FLD_DWELL: sh_dwell_d = clamp_time(wr_data_i, MAX_DWELL);
            FLD_EN:    sh_en_d    = wr_data_i[0];
         endcase
      end
   end

   // Active copy is taken from the registered shadow, so all four fields switch on one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh_phase_q  <= '0;
         sh_delay_q  <= '0;
         sh_dwell_q  <= '0;
         sh_en_q     <= 1'b0;
         act_phase_q <= '0;
         act_delay_q <= '0;
         act_dwell_q <= '0;
         act_en_q    <= 1'b0;
      end else begin
         sh_phase_q <= sh_phase_d;
         sh_delay_q <= sh_delay_d;
         sh_dwell_q <= sh_dwell_d;
         sh_en_q    <= sh_en_d;
         if (commit_i) begin
            act_phase_q <= sh_phase_q;
            act_delay_q <= sh_delay_q;
            act_dwell_q <= sh_dwell_q;
            act_en_q    <= sh_en_q;
         end
      end
   end

   assign phase_o = act_phase_q;
   assign delay_o = act_delay_q;
   assign dwell_o = act_dwell_q;
   assign en_o    = act_en_q;

endmodule

// File: rtl/ign_config_scheduler.sv
// rtl/ign_config_scheduler.sv - double-buffered channel timing config committed on engine-cycle boundary
module ign_config_scheduler
   import efi_cfg_pkg::*;
#(
   parameter int                N_CH      = 4,
   parameter logic [TIME_W-1:0] MAX_DWELL = 24'd20000
)
(
   input  logic                      clk,
   input  logic                      reset_n,
   ign_config_scheduler_if.slave     bus,
   output logic [PHASE_W*N_CH-1:0]   ch_phase,
   output logic [TIME_W*N_CH-1:0]    ch_delay,
   output logic [TIME_W*N_CH-1:0]    ch_dwell,
   output logic [N_CH-1:0]           ch_en
);

   state_e state_q;
   logic   wr_ready_q;
   logic   commit_pending_q;
   logic   commit_done_q;
   logic   synced_q;

   logic   boundary;
   logic   wr_acc;
   logic   commit_en;
   logic [2:0] wr_ch;
   fld_e   wr_field;

   assign boundary  = bus.synced & bus.trigger & (bus.eng_phase == '0);
   assign wr_acc    = bus.wr_en & wr_ready_q;
   assign commit_en = (state_q == ST_COMMIT);
   assign wr_ch     = bus.wr_addr[4:2];
   assign wr_field  = fld_e'(bus.wr_addr[1:0]);

   // Without sync there is no boundary to wait for, so an unsynced commit goes straight through.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         wr_ready_q       <= 1'b1;
         commit_pending_q <= 1'b0;
         commit_done_q    <= 1'b0;
         synced_q         <= 1'b0;
      end else begin
         synced_q <= bus.synced;
         case (state_q)
            ST_IDLE: begin
               if (bus.commit_req) begin
                  state_q          <= ST_PENDING;
                  wr_ready_q       <= 1'b0;
                  commit_pending_q <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (boundary || !bus.synced) begin
                  state_q       <= ST_COMMIT;
                  commit_done_q <= 1'b1;
               end
            end
            ST_COMMIT: begin
               state_q          <= ST_IDLE;
               commit_done_q    <= 1'b0;
               commit_pending_q <= 1'b0;
               wr_ready_q       <= 1'b1;
            end
            default: begin
               state_q          <= ST_IDLE;
               commit_done_q    <= 1'b0;
               commit_pending_q <= 1'b0;
               wr_ready_q       <= 1'b1;
            end
         endcase
      end
   end

   assign bus.wr_ready       = wr_ready_q;
   assign bus.commit_pending = commit_pending_q;
   assign bus.commit_done    = commit_done_q;

   // Channel indices at or above N_CH match no bank, so such writes fall away silently.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic sel;
      logic en_act;

      assign sel = wr_acc && (wr_ch == 3'(i));

      ign_cfg_bank #(
         .MAX_DWELL (MAX_DWELL)
      ) u_bank (
         .clk        (clk),
         .reset_n    (reset_n),
         .wr_en_i    (sel),
         .wr_field_i (wr_field),
         .wr_data_i  (bus.wr_data),
         .commit_i   (commit_en),
         .phase_o    (ch_phase[i*PHASE_W +: PHASE_W]),
         .delay_o    (ch_delay[i*TIME_W +: TIME_W]),
         .dwell_o    (ch_dwell[i*TIME_W +: TIME_W]),
         .en_o       (en_act)
      );

      assign ch_en[i] = en_act & synced_q;
   end

endmodule

// File: tb/tb_ign_config_scheduler.sv
// tb/tb_ign_config_scheduler.sv - directed self-checking bench for ign_config_scheduler
module tb_ign_config_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] ch_phase;
   logic [95:0] ch_delay;
   logic [95:0] ch_dwell;
   logic [3:0]  ch_en;

   int n_checks = 0;
   int n_fail   = 0;

   ign_config_scheduler_if bus();

   ign_config_scheduler #(
      .N_CH      (4),
      .MAX_DWELL (24'd20000)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .ch_phase (ch_phase),
      .ch_delay (ch_delay),
      .ch_dwell (ch_dwell),
      .ch_en    (ch_en)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [1:0] fld, input logic [23:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = {ch, fld};
      bus.wr_data = data;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic commit_pulse();
      bus.commit_req = 1'b1;
      tick();
      bus.commit_req = 1'b0;
   endtask

   task automatic boundary_pulse();
      bus.trigger   = 1'b1;
      bus.eng_phase = 8'd0;
      tick();
      bus.trigger   = 1'b0;
      bus.eng_phase = 8'd5;
   endtask

   task automatic do_commit();
      commit_pulse();
      boundary_pulse();
      tick();
   endtask

   task automatic test_reset();
      n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
      n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", bus.commit_pending); end
      n_checks++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.commit_done); end
      n_checks++; if ({ch_phase, ch_delay, ch_dwell, ch_en} !== '0) begin n_fail++; $display("FAIL reset_outputs got %h %h %h %h want 0", ch_phase, ch_delay, ch_dwell, ch_en); end
   endtask

   task automatic test_write_no_commit();
      wr(3'd1, 2'd0, 24'd30);
      wr(3'd1, 2'd1, 24'd1000);
      wr(3'd1, 2'd2, 24'd5000);
      wr(3'd1, 2'd3, 24'd1);
      tick();
      n_checks++; if ({ch_phase, ch_delay, ch_dwell, ch_en} !== '0) begin n_fail++; $display("FAIL nocommit_outputs got %h %h %h %h want 0", ch_phase, ch_delay, ch_dwell, ch_en); end
   endtask

   task automatic test_commit_boundary();
      bus.eng_phase = 8'd12;
      commit_pulse();
      n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL pend_set got %b want 1", bus.commit_pending); end
      n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL pend_wr_ready got %b want 0", bus.wr_ready); end
      bus.trigger = 1'b1;
      tick();
      bus.trigger = 1'b0;
      tick();
      n_checks++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL nonzero_phase_done got %b want 0", bus.commit_done); end
      n_checks++; if (ch_phase !== 32'h0) begin n_fail++; $display("FAIL pend_phase_unchanged got %h want 0", ch_phase); end
      boundary_pulse();
      n_checks++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL boundary_done got %b want 1", bus.commit_done); end
      n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL commit_pending_hold got %b want 1", bus.commit_pending); end
      tick();
      n_checks++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width got %b want 0", bus.commit_done); end
      n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL pending_clear got %b want 0", bus.commit_pending); end
      n_checks++; if (ch_phase[15:8] !== 8'd30) begin n_fail++; $display("FAIL ch1_phase got %0d want 30", ch_phase[15:8]); end
      n_checks++; if (ch_delay[47:24] !== 24'd1000) begin n_fail++; $display("FAIL ch1_delay got %0d want 1000", ch_delay[47:24]); end
      n_checks++; if (ch_dwell[47:24] !== 24'd5000) begin n_fail++; $display("FAIL ch1_dwell got %0d want 5000", ch_dwell[47:24]); end
      n_checks++; if (ch_en !== 4'b0010) begin n_fail++; $display("FAIL ch1_en got %b want 0010", ch_en); end
   endtask

   task automatic test_write_during_pending();
      wr(3'd2, 2'd1, 24'd777);
      commit_pulse();
      wr(3'd2, 2'd1, 24'd999);
      boundary_pulse();
      tick();
      n_checks++; if (ch_delay[71:48] !== 24'd777) begin n_fail++; $display("FAIL pending_write_dropped got %0d want 777", ch_delay[71:48]); end
      do_commit();
      n_checks++; if (ch_delay[71:48] !== 24'd777) begin n_fail++; $display("FAIL shadow_unchanged got %0d want 777", ch_delay[71:48]); end
   endtask

   task automatic test_dwell_clamp();
      wr(3'd0, 2'd2, 24'd50000);
      wr(3'd3, 2'd2, 24'd20000);
      do_commit();
      n_checks++; if (ch_dwell[23:0] !== 24'd20000) begin n_fail++; $display("FAIL dwell_clamp got %0d want 20000", ch_dwell[23:0]); end
      n_checks++; if (ch_dwell[95:72] !== 24'd20000) begin n_fail++; $display("FAIL dwell_at_max got %0d want 20000", ch_dwell[95:72]); end
   endtask

   task automatic test_simultaneous();
      bus.wr_en      = 1'b1;
      bus.wr_addr    = {3'd2, 2'd0};
      bus.wr_data    = 24'd99;
      bus.commit_req = 1'b1;
      tick();
      bus.wr_en      = 1'b0;
      bus.commit_req = 1'b0;
      boundary_pulse();
      tick();
      n_checks++; if (ch_phase[23:16] !== 8'd99) begin n_fail++; $display("FAIL simul_write got %0d want 99", ch_phase[23:16]); end
   endtask

   task automatic test_out_of_range();
      wr(3'd4, 2'd0, 24'h55);
      wr(3'd7, 2'd3, 24'd1);
      do_commit();
      n_checks++; if (ch_phase !== {8'd0, 8'd99, 8'd30, 8'd0}) begin n_fail++; $display("FAIL out_of_range_phase got %h want 00631e00", ch_phase); end
      n_checks++; if (ch_en !== 4'b0010) begin n_fail++; $display("FAIL out_of_range_en got %b want 0010", ch_en); end
   endtask

   task automatic test_unsynced_commit();
      wr(3'd3, 2'd0, 24'd77);
      wr(3'd3, 2'd3, 24'd1);
      bus.synced     = 1'b0;
      bus.commit_req = 1'b1;
      tick();
      bus.commit_req = 1'b0;
      n_checks++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL unsync_cycle1_done got %b want 0", bus.commit_done); end
      tick();
      n_checks++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL unsync_cycle2_done got %b want 1", bus.commit_done); end
      tick();
      n_checks++; if (ch_phase[31:24] !== 8'd77) begin n_fail++; $display("FAIL unsync_ch3_phase got %0d want 77", ch_phase[31:24]); end
      n_checks++; if (ch_en !== 4'b0000) begin n_fail++; $display("FAIL unsync_en_gated got %b want 0000", ch_en); end
      bus.synced = 1'b1;
      tick();
      n_checks++; if (ch_en !== 4'b1010) begin n_fail++; $display("FAIL resync_en got %b want 1010", ch_en); end
   endtask

   task automatic test_sync_drop();
      bus.synced = 1'b0;
      tick();
      n_checks++; if (ch_en !== 4'b0000) begin n_fail++; $display("FAIL drop_en got %b want 0000", ch_en); end
      n_checks++; if (ch_phase !== {8'd77, 8'd99, 8'd30, 8'd0}) begin n_fail++; $display("FAIL drop_retained got %h want 4d631e00", ch_phase); end
      bus.synced = 1'b1;
      tick();
      n_checks++; if (ch_en !== 4'b1010) begin n_fail++; $display("FAIL drop_restore got %b want 1010", ch_en); end
   endtask

   task automatic test_reset_mid_pending();
      commit_pulse();
      n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pending got %b want 1", bus.commit_pending); end
      reset_n = 1'b0;
      #1;
      n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending got %b want 0", bus.commit_pending); end
      n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready got %b want 1", bus.wr_ready); end
      n_checks++; if ({ch_phase, ch_delay, ch_dwell, ch_en} !== '0) begin n_fail++; $display("FAIL rst_async_outputs got %h %h %h %h want 0", ch_phase, ch_delay, ch_dwell, ch_en); end
      tick();
      reset_n = 1'b1;
      tick();
      boundary_pulse();
      n_checks++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL rst_request_discarded got %b want 0", bus.commit_done); end
      do_commit();
      n_checks++; if ({ch_phase, ch_delay, ch_dwell} !== '0) begin n_fail++; $display("FAIL rst_shadow_zeroed got %h %h %h want 0", ch_phase, ch_delay, ch_dwell); end
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.synced     = 1'b1;
      bus.eng_phase  = 8'd5;
      bus.trigger    = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.commit_req = 1'b0;
      tick();
      tick();
      test_reset();
      reset_n = 1'b1;
      tick();
      test_write_no_commit();
      test_commit_boundary();
      test_write_during_pending();
      test_dwell_clamp();
      test_simultaneous();
      test_out_of_range();
      test_unsynced_commit();
      test_sync_drop();
      test_reset_mid_pending();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
